// File: rtl/ct_lsu_dcache_tag_ctrl_if.sv
// Request/grant and tag-array bundle for the dcache tag controller.
// The controller side uses the slave modport.
interface ct_lsu_dcache_tag_ctrl_if;
  logic        cp0_lsu_dcache_inv_all;
  logic        ld_tag_req;
  logic [8:0]  ld_tag_idx;
  logic        snq_tag_req;
  logic [8:0]  snq_tag_idx;
  logic        rf_tag_req;
  logic [8:0]  rf_tag_idx;
  logic [51:0] rf_tag_din;
  logic [1:0]  rf_tag_wen;
  logic        ld_tag_grnt;
  logic        snq_tag_grnt;
  logic        rf_tag_grnt;
  logic        tag_rd_vld;
  logic [1:0]  tag_rd_src;
  logic        inv_busy;
  logic        inv_done;
  logic [8:0]  tag_idx;
  logic [51:0] tag_din;
  logic        tag_sel_b;
  logic        tag_gwen_b;
  logic [1:0]  tag_wen_b;
  logic        tag_gateclk_en;

  modport slave (
    input  cp0_lsu_dcache_inv_all,
    input  ld_tag_req, ld_tag_idx,
    input  snq_tag_req, snq_tag_idx,
    input  rf_tag_req, rf_tag_idx,
    input  rf_tag_din, rf_tag_wen,
    output ld_tag_grnt, snq_tag_grnt,
    output rf_tag_grnt,
    output tag_rd_vld, tag_rd_src,
    output inv_busy, inv_done,
    output tag_idx, tag_din, tag_sel_b,
    output tag_gwen_b, tag_wen_b,
    output tag_gateclk_en
  );

  modport master (
    output cp0_lsu_dcache_inv_all,
    output ld_tag_req, ld_tag_idx,
    output snq_tag_req, snq_tag_idx,
    output rf_tag_req, rf_tag_idx,
    output rf_tag_din, rf_tag_wen,
    input  ld_tag_grnt, snq_tag_grnt,
    input  rf_tag_grnt,
    input  tag_rd_vld, tag_rd_src,
    input  inv_busy, inv_done,
    input  tag_idx, tag_din, tag_sel_b,
    input  tag_gwen_b, tag_wen_b,
    input  tag_gateclk_en
  );
endinterface

// File: rtl/ct_lsu_dcache_tag_ctrl.sv
// Dcache tag-array arbiter with invalidate sweep and snoop anti-starvation.
// LSU_DCACHE_TAG_64K_EN selects 512 sets; default is 256 sets.
module ct_lsu_dcache_tag_ctrl (
  input  logic forever_cpuclk,
  input  logic cpurst,
  ct_lsu_dcache_tag_ctrl_if.slave bus
);

`ifdef LSU_DCACHE_TAG_64K_EN
  localparam logic [8:0] IDX_MASK = 9'h1ff;
  localparam logic [8:0] LAST_IDX = 9'h1ff;
`else
  localparam logic [8:0] IDX_MASK = 9'h0ff;
  localparam logic [8:0] LAST_IDX = 9'h0ff;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [1:0]  starve_q, starve_d;
  logic        rd_vld_q;
  logic [1:0]  rd_src_q;
  logic        busy;
  logic        avail;
  logic        sweep_wr;
  logic        snq_boost;
  logic        rf_g, snq_g, ld_g;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cp0_lsu_dcache_inv_all) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign avail    = !busy && !cpurst;
  assign sweep_wr = (state_q == SWEEP) && !cpurst;

  // a starved snoop jumps ahead of refill for exactly one grant
  assign snq_boost = (starve_q == 2'd3) && bus.snq_tag_req;
  assign rf_g  = avail && bus.rf_tag_req && !snq_boost;
  assign snq_g = avail && bus.snq_tag_req && !rf_g;
  assign ld_g  = avail && bus.ld_tag_req && !rf_g && !snq_g;

  always_comb begin
    starve_d = starve_q;
    if (snq_g)
      starve_d = 2'd0;
    else if (bus.snq_tag_req && starve_q != 2'd3)
      starve_d = starve_q + 2'd1;
  end

  always_comb begin
    bus.tag_sel_b  = 1'b1;
    bus.tag_gwen_b = 1'b1;
    bus.tag_wen_b  = 2'b11;
    bus.tag_idx    = '0;
    bus.tag_din    = '0;
    unique case (1'b1)
      sweep_wr: begin
        bus.tag_sel_b  = 1'b0;
        bus.tag_gwen_b = 1'b0;
        bus.tag_wen_b  = 2'b00;
        bus.tag_idx    = cnt_q & IDX_MASK;
      end
      rf_g: begin
        bus.tag_sel_b  = 1'b0;
        bus.tag_gwen_b = 1'b0;
        bus.tag_wen_b  = ~bus.rf_tag_wen;
        bus.tag_idx    = bus.rf_tag_idx & IDX_MASK;
        bus.tag_din    = bus.rf_tag_din;
      end
      snq_g: begin
        bus.tag_sel_b = 1'b0;
        bus.tag_idx   = bus.snq_tag_idx & IDX_MASK;
      end
      ld_g: begin
        bus.tag_sel_b = 1'b0;
        bus.tag_idx   = bus.ld_tag_idx & IDX_MASK;
      end
      default: ;
    endcase
    bus.tag_gateclk_en = !bus.tag_sel_b;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= 2'd0;
      rd_vld_q <= 1'b0;
      rd_src_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      rd_vld_q <= snq_g | ld_g;
      rd_src_q <= {snq_g, ld_g};
    end
  end

  assign bus.ld_tag_grnt  = ld_g;
  assign bus.snq_tag_grnt = snq_g;
  assign bus.rf_tag_grnt  = rf_g;
  assign bus.tag_rd_vld   = rd_vld_q;
  assign bus.tag_rd_src   = rd_src_q;
  assign bus.inv_busy     = busy;
  assign bus.inv_done     = (state_q == DONE);

endmodule

// File: doc/ct_lsu_dcache_tag_ctrl.md
CT_LSU_DCACHE_TAG_CTRL -- requirements
Module: ct_lsu_dcache_tag_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first (name  dir  width  meaning):
- forever_cpuclk  in  1  sole clock.
- cpurst  in  1  synchronous active-high reset.
- cp0_lsu_dcache_inv_all  in  1  pulse; start whole-array invalidate sweep.
- ld_tag_req / ld_tag_idx  in  1 / 9  load-pipe tag read request and index.
- snq_tag_req / snq_tag_idx  in  1 / 9  snoop tag read request and index.
- rf_tag_req / rf_tag_idx / rf_tag_din / rf_tag_wen  in  1 / 9 / 52 / 2  refill tag write: request, index, data, per-way write enable (1 = write way).
- ld_tag_grnt / snq_tag_grnt / rf_tag_grnt  out  1 each  grant, same cycle as request.
- tag_rd_vld / tag_rd_src  out  1 / 2  read data valid; source (01 = load, 10 = snoop).
- inv_busy / inv_done  out  1 / 1  sweep active; one-cycle pulse at sweep end.
- tag_idx / tag_din / tag_sel_b / tag_gwen_b / tag_wen_b / tag_gateclk_en  out  9 / 52 / 1 / 1 / 2 / 1  tag-array drive (active-low select, global write, and per-way write).
REQ-002 SHALL use only the clock and reset given in REQ-001: one clock, synchronous active-high reset.

Function
REQ-003 SHALL grant at most one requester per cycle.
REQ-004 SHALL use fixed priority sweep > refill > snoop > load, except as REQ-005 allows.
REQ-005 SHALL keep a 2-bit snoop-starve counter:
- increments each cycle snq_tag_req is denied;
- clears on snoop grant;
- at value 3, snoop outranks refill for one grant.
REQ-006 SHALL drive the tag-array outputs combinationally from the granted request. With no grant: tag_sel_b=1, tag_gwen_b=1, tag_wen_b=2'b11, tag_gateclk_en=0.
REQ-007 SHALL drive reads with tag_sel_b=0 and tag_gwen_b=1.
REQ-008 SHALL drive writes with tag_sel_b=0, tag_gwen_b=0, tag_wen_b=~rf_tag_wen and tag_din=rf_tag_din.
REQ-009 SHALL assert tag_gateclk_en in every cycle where tag_sel_b=0.
REQ-010 SHALL assert tag_rd_vld exactly one cycle after a read grant, with tag_rd_src registered from that grant.
REQ-011 SHALL implement the sweep FSM with states IDLE, SWEEP and DONE:
- IDLE->SWEEP on cp0_lsu_dcache_inv_all;
- SWEEP writes tag_din=0 with tag_wen_b=2'b00 at counter index 0..N-1, one index per cycle;
- SWEEP->DONE after index N-1;
- DONE->IDLE after one cycle, pulsing inv_done.
REQ-012 SHALL hold inv_busy=1 in SWEEP and DONE. While inv_busy=1, SHALL deny all grants.
REQ-013 SHALL ignore cp0_lsu_dcache_inv_all while not in IDLE; no restart and no queuing.
REQ-014 SHALL wrap the sweep counter to 0 on SWEEP exit.
REQ-015 SHALL NOT hold requests internally; a denied requester re-presents its request.
REQ-016 SHALL let a write grant coincide with a pending tag_rd_vld from the previous cycle without corrupting tag_rd_src.

Reset
REQ-017 SHALL, on cpurst=1 at a clock edge:
- put the FSM in IDLE and clear the sweep and starve counters;
- drive tag_rd_vld=0, tag_rd_src=00, inv_busy=0, inv_done=0 and all grants 0;
- drive the tag-array outputs idle per REQ-006.
REQ-018 SHALL abort a sweep when cpurst is asserted mid-sweep, with no inv_done pulse.

Configuration
REQ-019 SHALL use macro LSU_DCACHE_TAG_64K_EN:
- defined: N=512 and all 9 tag_idx bits driven from the request or sweep counter;
- undefined: N=256, tag_idx[8] tied to 0 and request index bit 8 ignored.

Verification
REQ-020 ld_tag_req=1 with idx=0x05 alone -> ld_tag_grnt=1, tag_sel_b=0, tag_gwen_b=1, tag_idx=0x05; next cycle tag_rd_vld=1, tag_rd_src=01.
REQ-021 rf_tag_req, snq_tag_req and ld_tag_req all asserted on cycle 0 -> rf granted on cycle 0 with tag_wen_b=~rf_tag_wen; snq granted once rf drops.
REQ-022 rf_tag_req held high for 5 cycles with snq_tag_req also high -> snq granted on the 4th cycle; starve counter reads 0 afterwards.
REQ-023 inv_all pulse with 64K_EN defined -> 512 write cycles at idx 0..511 with din=0 and wen_b=00; inv_done pulses on cycle 513; ld_tag_req is denied throughout.
REQ-024 cpurst=1 at sweep idx 100 -> next cycle inv_busy=0, tag_sel_b=1, no inv_done pulse; a fresh inv_all restarts the sweep at idx 0.
REQ-025 64K_EN undefined, ld_tag_idx=0x1FF -> tag_idx=0x0FF; sweep ends at idx 255.
